core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin execution from IDLE.
REQ-005 halt_req  input  1  request stop at the next instruction boundary.
REQ-006 opcode  input  6  instruction opcode field from the instruction parser.
REQ-007 funct  input  6  instruction funct field.
REQ-008 mem_ready  input  1  memory completes the current read or write this cycle.
REQ-009 ir_write  output  1  latch instruction word.
REQ-010 alu_en  output  1  ALU evaluates.
REQ-011 mem_read  output  1  memory read request.
REQ-012 mem_write  output  1  memory write request.
REQ-013 reg_write  output  1  register file write.
REQ-014 pc_write  output  1  PC update; marks instruction retirement.
REQ-015 busy  output  1  state is not IDLE and not FAULT.
REQ-016 state  output  3  encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
REQ-017 instr_count  output  16  count of retired instructions.
REQ-018 fault  output  1  memory timeout detected.

Function
REQ-019 IDLE SHALL go to FETCH when start=1; start SHALL be ignored in every other state.
REQ-020 FETCH SHALL assert mem_read.
REQ-021 In FETCH, when mem_ready=1, the block SHALL assert ir_write in the same cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-022 DECODE SHALL register opcode and funct internally and go to EXEC after 1 cycle; later decisions SHALL use only the registered copies.
REQ-023 EXEC SHALL assert alu_en.
REQ-024 From EXEC, opcode 0x23 (lw) or 0x2B (sw) SHALL go to MEM.
REQ-025 From EXEC, opcode 0x02 (j), 0x04 or 0x05 (branch), or opcode 0x00 with funct 0x08 (jr) SHALL assert pc_write and retire.
REQ-026 From EXEC, all other instructions SHALL go to WB.
REQ-027 MEM SHALL assert mem_read for lw and mem_write for sw, held until mem_ready=1.
REQ-028 In MEM with mem_ready=1, lw SHALL go to WB; sw SHALL assert pc_write and retire.
REQ-029 WB SHALL assert reg_write and pc_write for 1 cycle, then retire.
REQ-030 Retire SHALL go to FETCH, or to IDLE if a halt is pending.
REQ-031 halt_req SHALL be latched on any cycle it is high and cleared on entry to IDLE.
REQ-032 If halt_req is high in the same cycle as a retirement, that retirement SHALL go to IDLE.
REQ-033 instr_count SHALL increment by 1 on every pc_write pulse and wrap from 0xFFFF to 0x0000.
REQ-034 Strobes SHALL be decoded from the current state and mem_ready, and SHALL be 0 in IDLE and FAULT.
REQ-035 mem_read and mem_write SHALL never be high together.
REQ-036 Minimum instruction latency SHALL be 4 cycles for ALU ops (FETCH, DECODE, EXEC, WB) and 3 cycles for jumps, each with a single-cycle fetch.

Reset
REQ-037 reset_n=0 SHALL immediately force IDLE, clear the halt latch and instr_count, and set fault=0 and all strobes to 0, including when asserted mid-instruction.
REQ-038 After reset release, the block SHALL stay in IDLE until start=1.

Configuration
REQ-039 Macro SEQ_TIMEOUT_EN, when defined, SHALL enable a 4-bit wait counter that counts consecutive FETCH/MEM cycles with mem_ready=0.
REQ-040 With SEQ_TIMEOUT_EN, the wait counter SHALL clear on mem_ready=1 or state change.
REQ-041 With SEQ_TIMEOUT_EN, on the 16th consecutive wait cycle the block SHALL go to FAULT and set fault=1; FAULT SHALL exit only via reset.
REQ-042 Without SEQ_TIMEOUT_EN, waits SHALL be unbounded, FAULT SHALL be unreachable, and fault SHALL be tied to 0.

Verification
REQ-043 Reset, start, ALU op (opcode 0x00, funct 0x20), mem_ready=1 -> states 1,2,3,5,1; reg_write and pc_write in WB; instr_count=1.
REQ-044 lw (0x23) with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles; WB follows; sw (0x2B) -> mem_write held, no reg_write, pc_write on ready.
REQ-045 j (0x02) then jr (0x00/0x08) -> each retires from EXEC with no WB; instr_count +2.
REQ-046 halt_req pulse during DECODE -> current instruction completes, then state=0, busy=0; start during execution -> ignored.
REQ-047 reset_n low in MEM -> state=0 and all strobes 0 asynchronously; instr_count preloaded to 0xFFFF by 65535 retirements, one more -> 0x0000.
REQ-048 With SEQ_TIMEOUT_EN, mem_ready held 0 in FETCH -> FAULT after 16 cycles, fault=1; without the macro -> remains in FETCH, fault=0.

Source files
------------

// File: rtl/core_sequencer_if.sv
// ============================================================================
// core_sequencer_if
//   Control/handshake bundle between the instruction sequencer and its
//   environment (instruction parser, memory, datapath).
//   modport slave  : the sequencer's view
//   modport master : the environment's view
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_sequencer_if;
  logic        start;
  logic        halt_req;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;

  logic        ir_write;
  logic        alu_en;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        pc_write;
  logic        busy;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic        fault;

  modport slave (
    input  start, halt_req, opcode, funct, mem_ready,
    output ir_write, alu_en, mem_read, mem_write, reg_write, pc_write,
           busy, state, instr_count, fault
  );

  modport master (
    output start, halt_req, opcode, funct, mem_ready,
    input  ir_write, alu_en, mem_read, mem_write, reg_write, pc_write,
           busy, state, instr_count, fault
  );
endinterface

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// core_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
//   Control strobes are decoded from the current state and mem_ready, so
//   ir_write / pc_write respond in the same cycle memory completes.
//   Optional macro SEQ_TIMEOUT_EN adds a memory-wait watchdog that drives the
//   sequencer into FAULT after 16 consecutive wait cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer (
  input  wire logic      clock,
  input  wire logic      reset_n,
  core_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JR      = 6'h08;

  state_t      state_q;
  logic [5:0]  opcode_q;
  logic [5:0]  funct_q;
  logic        halt_q;
  logic [15:0] count_q;

  // Instruction class, taken only from the copies captured in DECODE
  logic is_load;
  logic is_store;
  logic is_jump;

  assign is_load  = (opcode_q == OP_LW);
  assign is_store = (opcode_q == OP_SW);
  assign is_jump  = (opcode_q == OP_J) || (opcode_q == OP_BEQ) ||
                    (opcode_q == OP_BNE) ||
                    ((opcode_q == OP_SPECIAL) && (funct_q == FN_JR));

  // A halt seen this cycle counts as pending even before it is latched
  logic   halt_pending;
  state_t retire_state;

  assign halt_pending = halt_q | bus.halt_req;
  assign retire_state = halt_pending ? S_IDLE : S_FETCH;

  logic timeout;

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] wait_q;
  logic       waiting;

  // FETCH/MEM are only left on mem_ready or timeout, both of which clear the
  // counter, so "consecutive waits in the same state" needs no extra tracking
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
  assign timeout = waiting && (wait_q == 4'hF);

  // Count consecutive memory-wait cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= 4'd0;
    end else if (waiting && !timeout) begin
      wait_q <= wait_q + 4'd1;
    end else begin
      wait_q <= 4'd0;
    end
  end

  assign bus.fault = (state_q == S_FAULT);
`else
  assign timeout   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  // Strobe decode; everything stays low in IDLE and FAULT
  logic ir_write;
  logic alu_en;
  logic mem_read;
  logic mem_write;
  logic reg_write;
  logic pc_write;

  // Decode control strobes from the current state and memory handshake
  always_comb begin
    ir_write  = 1'b0;
    alu_en    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
      end
      S_EXEC: begin
        alu_en   = 1'b1;
        pc_write = is_jump;
      end
      S_MEM: begin
        // lw and sw are exclusive opcodes, so read/write never overlap
        mem_read  = is_load;
        mem_write = is_store;
        pc_write  = is_store && bus.mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.ir_write    = ir_write;
  assign bus.alu_en      = alu_en;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.reg_write   = reg_write;
  assign bus.pc_write    = pc_write;
  assign bus.state       = state_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.instr_count = count_q;

  // Sequencer state, halt latch and captured instruction fields
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      halt_q   <= 1'b0;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
    end else begin
      if (bus.halt_req) begin
        halt_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout) begin
            state_q <= S_FAULT;
          end
        end
        S_DECODE: begin
          opcode_q <= bus.opcode;
          funct_q  <= bus.funct;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          // jumps/branches retire here through pc_write below
          if (is_load || is_store) begin
            state_q <= S_MEM;
          end else if (!is_jump) begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          // a completing store retires through pc_write below
          if (bus.mem_ready) begin
            if (is_load) begin
              state_q <= S_WB;
            end
          end else if (timeout) begin
            state_q <= S_FAULT;
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= state_q;
        end
      endcase

      // Retirement: back to FETCH, or IDLE when a halt is pending; entering
      // IDLE consumes the halt
      if (pc_write) begin
        state_q <= retire_state;
        if (halt_pending) begin
          halt_q <= 1'b0;
        end
      end
    end
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'd0;
    end else if (pc_write) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
// tb_core_sequencer
//   Self-checking bench: directed scenarios with literal expectations plus
//   randomized traffic compared every cycle against an instruction-level
//   reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_sequencer;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  core_sequencer_if bus ();

  core_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int K_ALU   = 0;
  localparam int K_JUMP  = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h23) return K_LOAD;
    if (op == 6'h2B) return K_STORE;
    if (op == 6'h02 || op == 6'h04 || op == 6'h05 || (op == 6'h00 && fn == 6'h08))
      return K_JUMP;
    return K_ALU;
  endfunction

  int          m_st;
  logic [5:0]  m_op = 6'd0;
  logic [5:0]  m_fn = 6'd0;
  bit          m_halt;
  logic [15:0] m_cnt;
  int          m_wait;

  int          k, nxt;
  bit          rdy, e_ir, e_alu, e_rd, e_wr, e_rw, e_pw, e_busy, e_fault, hit;
  logic [31:0] exp_v, got_v;

  // Every cycle: predict outputs from the model, compare, then advance it
  always @(negedge clock) begin
    if (!reset_n) begin
      m_st = 0; m_halt = 0; m_cnt = 16'd0; m_wait = 0;
    end
    k   = kind_of(m_op, m_fn);
    rdy = bus.mem_ready;
    e_ir    = (m_st == 1) && rdy;
    e_alu   = (m_st == 3);
    e_rd    = (m_st == 1) || (m_st == 4 && k == K_LOAD);
    e_wr    = (m_st == 4 && k == K_STORE);
    e_rw    = (m_st == 5);
    e_pw    = (m_st == 3 && k == K_JUMP) || (m_st == 4 && k == K_STORE && rdy) || (m_st == 5);
    e_busy  = (m_st >= 1 && m_st <= 5);
    e_fault = (m_st == 6);
    exp_v = {5'd0, e_ir, e_alu, e_rd, e_wr, e_rw, e_pw, e_busy, e_fault, 3'(m_st), m_cnt};
    got_v = {5'd0, bus.ir_write, bus.alu_en, bus.mem_read, bus.mem_write, bus.reg_write,
             bus.pc_write, bus.busy, bus.fault, bus.state, bus.instr_count};
    check("cycle_outputs", got_v, exp_v);
    if (bus.mem_read && bus.mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);

    if (reset_n) begin
`ifdef SEQ_TIMEOUT_EN
      hit = (m_st == 1 || m_st == 4) && !rdy && (m_wait == 15);
`else
      hit = 1'b0;
`endif
      nxt = m_st;
      if (e_pw) begin
        m_cnt = m_cnt + 16'd1;
        nxt = (m_halt || bus.halt_req) ? 0 : 1;
      end else begin
        case (m_st)
          0: if (bus.start) nxt = 1;
          1: if (rdy) nxt = 2; else if (hit) nxt = 6;
          2: begin m_op = bus.opcode; m_fn = bus.funct; nxt = 3; end
          3: nxt = (k == K_LOAD || k == K_STORE) ? 4 : 5;
          4: if (rdy) nxt = 5; else if (hit) nxt = 6;
          default: nxt = m_st;
        endcase
      end
      if (nxt == 0 && m_st != 0) m_halt = 0;
      else if (bus.halt_req)     m_halt = 1;
      if ((m_st == 1 || m_st == 4) && !rdy && !hit) m_wait = m_wait + 1;
      else                                           m_wait = 0;
      m_st = nxt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.opcode = 6'd0;
    bus.funct = 6'd0; bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

  logic [5:0] op_tab [6] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h23, 6'h2B};
  int n_rd;

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    do_reset();

    // reset state
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_count", 32'(bus.instr_count), 32'd0);
    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_fault", 32'(bus.fault), 32'd0);

    // ALU op: 1,2,3,5,1
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1; bus.start = 1'b1;
    tick(); check("alu_s_fetch", 32'(bus.state), 32'd1); bus.start = 1'b0;
    tick(); check("alu_s_decode", 32'(bus.state), 32'd2);
    tick(); check("alu_s_exec", 32'(bus.state), 32'd3);
    check("alu_en_exec", 32'(bus.alu_en), 32'd1);
    tick(); check("alu_s_wb", 32'(bus.state), 32'd5);
    check("alu_wb_strobes", 32'({bus.reg_write, bus.pc_write}), 32'd3);
    tick(); check("alu_s_refetch", 32'(bus.state), 32'd1);
    check("alu_count", 32'(bus.instr_count), 32'd1);

    // lw with three wait cycles in MEM
    do_reset();
    bus.opcode = 6'h23; bus.mem_ready = 1'b1; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    n_rd = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      if (bus.state == 3'd4 && bus.mem_read) n_rd++;
      tick();
    end
    check("lw_read_cycles", 32'(n_rd), 32'd4);
    check("lw_s_wb", 32'(bus.state), 32'd5);
    check("lw_reg_write", 32'(bus.reg_write), 32'd1);
    tick();

    // sw: write held, no WB, retire on ready
    bus.opcode = 6'h2B;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    check("sw_wait_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write}), 32'b0100);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("sw_ready_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write}), 32'b0101);
    tick();
    check("sw_s_refetch", 32'(bus.state), 32'd1);
    check("sw_count", 32'(bus.instr_count), 32'd2);

    // j then jr retire from EXEC
    bus.opcode = 6'h02;
    tick(); tick();
    check("j_pc_write", 32'({bus.reg_write, bus.pc_write}), 32'b01);
    tick(); check("j_no_wb", 32'(bus.state), 32'd1);
    bus.opcode = 6'h00; bus.funct = 6'h08;
    tick(); tick();
    check("jr_pc_write", 32'({bus.reg_write, bus.pc_write}), 32'b01);
    tick(); check("jr_no_wb", 32'(bus.state), 32'd1);
    check("jump_count", 32'(bus.instr_count), 32'd4);

    // halt during DECODE; start ignored mid-instruction
    do_reset();
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); bus.halt_req = 1'b1;
    tick(); bus.halt_req = 1'b0; bus.start = 1'b1;
    tick(); check("halt_s_wb", 32'(bus.state), 32'd5); bus.start = 1'b0;
    tick(); check("halt_idle", 32'({bus.state, bus.busy}), 32'd0);
    tick(); check("halt_stays_idle", 32'(bus.state), 32'd0);
    check("halt_count", 32'(bus.instr_count), 32'd1);
    bus.start = 1'b1;
    tick(); check("restart_after_halt", 32'(bus.state), 32'd1);
    bus.start = 1'b0;

    // asynchronous reset while in MEM
    bus.opcode = 6'h23;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    check("mem_before_reset", 32'(bus.state), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_state", 32'(bus.state), 32'd0);
    check("async_reset_strobes", 32'({bus.ir_write, bus.alu_en, bus.mem_read, bus.mem_write,
                                      bus.reg_write, bus.pc_write, bus.busy}), 32'd0);
    check("async_reset_count", 32'(bus.instr_count), 32'd0);
    tick();
    reset_n = 1'b1;
    clear_inputs();
    tick();

    // counter wrap: preload 0xFFFF, one more retirement -> 0x0000
    force dut.count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #2 release dut.count_q;
    bus.opcode = 6'h02; bus.mem_ready = 1'b1; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    check("wrap_before", 32'(bus.instr_count), 32'hFFFF);
    tick();
    check("wrap_after", 32'(bus.instr_count), 32'h0000);

    // memory never ready in FETCH
    do_reset();
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    repeat (15) tick();
    check("timeout_15_waits", 32'(bus.state), 32'd1);
    tick();
`ifdef SEQ_TIMEOUT_EN
    check("timeout_fault_state", 32'({bus.state, bus.fault, bus.busy}), 32'b11010);
    bus.mem_ready = 1'b1; bus.start = 1'b1;
    tick(); tick();
    check("fault_sticky", 32'(bus.state), 32'd6);
`else
    check("no_timeout_state", 32'({bus.state, bus.fault, bus.busy}), 32'b00101);
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.start     = ($urandom_range(0, 99) < 30);
      bus.halt_req  = ($urandom_range(0, 99) < 3);
      bus.mem_ready = ($urandom_range(0, 99) < 75);
      bus.opcode    = ($urandom_range(0, 7) < 6) ? op_tab[$urandom_range(0, 5)] : 6'($urandom);
      bus.funct     = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'($urandom);
      reset_n       = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    clear_inputs();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
